// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
// FSM state encoding plus default parameter values.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_DEFAULT_STABLE = 16;
  localparam int DEBOUNCE_DEFAULT_SYNC   = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for one asynchronous pin.
// Reused for other asynchronous inputs; async active-low reset.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  // shift the raw pin through DEPTH flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[DEPTH-2:0], d};
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw pin into a registered level with optional edge pulses.
// Define INPUT_DEBOUNCER_PULSE_EN to build the rise/fall pulse registers.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_STABLE,
  parameter int SYNC_STAGES   = DEBOUNCE_DEFAULT_SYNC
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  debounce_state_t  state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n;
  logic             din_sync;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_raw),
    .q     (din_sync)
  );

  // state, counter and level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
    end
  end

  // next-state: count consecutive cycles at the opposite level
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    unique case (state)
      STABLE_LOW: begin
        cnt_n = '0;
        if (din_sync) begin
          state_n = CHECK_HIGH;
          cnt_n   = ONE;
        end
      end
      CHECK_HIGH: begin
        if (!din_sync) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          dout_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STABLE_HIGH: begin
        cnt_n = '0;
        if (!din_sync) begin
          state_n = CHECK_LOW;
          cnt_n   = ONE;
        end
      end
      CHECK_LOW: begin
        if (din_sync) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          dout_n  = 1'b0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
        dout_n  = 1'b0;
      end
    endcase
  end

`ifdef INPUT_DEBOUNCER_PULSE_EN
  // pulses coincide with the cycle dout shows its new value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= dout_n & ~dout;
      fall <= ~dout_n & dout;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised self-checking bench for input_debouncer.
// Uses STABLE_CYCLES=4, SYNC_STAGES=2 and a run-length reference model.
module tb_input_debouncer;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = STABLE + SYNC;
`ifdef INPUT_DEBOUNCER_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic din_raw;
  logic dout, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: level flips after STABLE consecutive
  // synchronised samples that disagree with it
  bit [SYNC-1:0] msync;
  bit            mlevel, mrise, mfall;
  int            mrun;

  input_debouncer #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .din_raw (din_raw),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  // behavioural model
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      msync  <= '0;
      mlevel <= 1'b0;
      mrun   <= 0;
      mrise  <= 1'b0;
      mfall  <= 1'b0;
    end else begin
      mrise <= 1'b0;
      mfall <= 1'b0;
      if (msync[SYNC-1] == mlevel) begin
        mrun <= 0;
      end else if (mrun + 1 >= STABLE) begin
        mlevel <= msync[SYNC-1];
        mrun   <= 0;
        mrise  <= msync[SYNC-1];
        mfall  <= !msync[SYNC-1];
      end else begin
        mrun <= mrun + 1;
      end
      msync <= {msync[SYNC-2:0], din_raw};
    end
  end

  task automatic settle(input logic v);
    din_raw = v;
    repeat (LAT + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    din_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold: dout/rise/fall=%b expected 000", {dout, rise, fall});
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== (e >= LAT) || rise !== (PULSE && e == LAT) || fall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release e=%0d: dout=%b rise=%b fall=%b expected %b %b 0",
                 e, dout, rise, fall, e >= LAT, PULSE && e == LAT);
      end
    end
    // asynchronous clear while dout is high
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({dout, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: dout/rise/fall=%b expected 000", {dout, rise, fall});
    end
    din_raw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    settle(1'b0);
  endtask

  task automatic test_clean_press();
    din_raw = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== (e >= LAT) || rise !== (PULSE && e == LAT) || fall !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_press e=%0d: dout=%b rise=%b fall=%b expected %b %b 0",
                 e, dout, rise, fall, e >= LAT, PULSE && e == LAT);
      end
    end
    settle(1'b0);
  endtask

  task automatic test_glitch();
    din_raw = 1'b1;
    for (int e = 1; e <= LAT + 8; e++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch3 e=%0d: dout/rise/fall=%b expected 000", e, {dout, rise, fall});
      end
      if (e == STABLE - 1) din_raw = 1'b0;
    end
    din_raw = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== (e >= LAT) || rise !== (PULSE && e == LAT) || fall !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch4 e=%0d: dout=%b rise=%b fall=%b expected %b %b 0",
                 e, dout, rise, fall, e >= LAT, PULSE && e == LAT);
      end
      if (e == STABLE) din_raw = 1'b0;
    end
    settle(1'b0);
  endtask

  task automatic test_bouncy_release();
    bit [0:8] pat = 9'b010010000;
    int       nfall = 0;
    // last 0-run starts at index 5: FSM sees it SYNC+1 edges later
    int       fe = 5 + SYNC + STABLE;
    settle(1'b1);
    din_raw = pat[0];
    for (int e = 1; e <= fe + 4; e++) begin
      @(negedge clk);
      if (fall === 1'b1) nfall++;
      n_checks++;
      if (dout !== (e < fe) || fall !== (PULSE && e == fe) || rise !== 1'b0) begin
        n_fail++;
        $display("FAIL bouncy e=%0d: dout=%b rise=%b fall=%b expected %b 0 %b",
                 e, dout, rise, fall, e < fe, PULSE && e == fe);
      end
      din_raw = (e < 9) ? pat[e] : 1'b0;
    end
    n_checks++;
    if (nfall != (PULSE ? 1 : 0)) begin
      n_fail++;
      $display("FAIL bouncy_count: falls=%0d expected %0d", nfall, PULSE ? 1 : 0);
    end
    settle(1'b0);
  endtask

  task automatic test_reset_mid_check();
    din_raw = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({dout, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset: dout/rise/fall=%b expected 000", {dout, rise, fall});
    end
    din_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= LAT + 4; e++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL midreset_quiet e=%0d: dout/rise/fall=%b expected 000", e, {dout, rise, fall});
      end
    end
    // a fresh press must take the full latency again
    din_raw = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== (e >= LAT) || rise !== (PULSE && e == LAT)) begin
        n_fail++;
        $display("FAIL midreset_restart e=%0d: dout=%b rise=%b expected %b %b",
                 e, dout, rise, e >= LAT, PULSE && e == LAT);
      end
    end
    settle(1'b0);
  endtask

  task automatic test_random();
    int run = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== mlevel || rise !== (PULSE && mrise) || fall !== (PULSE && mfall)
          || (rise && fall)) begin
        n_fail++;
        $display("FAIL random c=%0d: dout=%b rise=%b fall=%b expected %b %b %b",
                 c, dout, rise, fall, mlevel, PULSE && mrise, PULSE && mfall);
      end
      if (run == 0) begin
        din_raw = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 2 * STABLE);
      end
      run--;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_reset_mid_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
